pcs_dec_lite: RTL and testbench

//  - Receive-side 64b/66b PCS decoder. Sits after block lock/descrambler, before MAC RX.
//  - Classifies each 66b block (sync header + block type) into control/idle/start/term/data.
//  - Tracks packet framing with an RX state machine, flags protocol errors, emits data + byte keep.
//  - Registered output, 1-cycle latency.

---
 rtl/pcs_pkg.sv | 82 ++++++++
 rtl/pcs_dec_block_type.sv | 55 +++++
 rtl/pcs_dec_lite.sv | 205 ++++++++++++++++++++
 tb/tb_pcs_dec_lite.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// pcs_pkg
//   Shared constants and types for the 64b/66b receive decoder:
//   sync header codes, block type bytes, the idle control code,
//   the RX framing state and the block classification, plus two helpers
//   (framing next-state and per-block byte keep).
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] BLOCK_TYPE_CTRL   = 8'h1e;
  localparam logic [7:0] BLOCK_TYPE_START0 = 8'h78;
  localparam logic [7:0] BLOCK_TYPE_START4 = 8'h33;
  localparam logic [7:0] BLOCK_TYPE_TERM0  = 8'h87;
  localparam logic [7:0] BLOCK_TYPE_TERM1  = 8'h99;
  localparam logic [7:0] BLOCK_TYPE_TERM2  = 8'haa;
  localparam logic [7:0] BLOCK_TYPE_TERM3  = 8'hb4;
  localparam logic [7:0] BLOCK_TYPE_TERM4  = 8'hcc;
  localparam logic [7:0] BLOCK_TYPE_TERM5  = 8'hd2;
  localparam logic [7:0] BLOCK_TYPE_TERM6  = 8'he1;
  localparam logic [7:0] BLOCK_TYPE_TERM7  = 8'hff;

  localparam logic [6:0] CTRL_IDLE = 7'h07;

  // Complete all-idle control block payload: type byte plus seven idle codes.
  localparam logic [63:0] IDLE_BLOCK = {{7{CTRL_IDLE}}, BLOCK_TYPE_CTRL};

  typedef enum logic [1:0] {
    RX_C = 2'd0,
    RX_D = 2'd1,
    RX_E = 2'd2
  } rx_state_t;

  typedef enum logic [2:0] {
    BLK_CTRL   = 3'd0,
    BLK_START0 = 3'd1,
    BLK_START4 = 3'd2,
    BLK_TERM   = 3'd3,
    BLK_DATA   = 3'd4,
    BLK_ERR    = 3'd5
  } block_class_t;

  // Framing state after a complete block of class cls arrives in state st.
  function automatic rx_state_t rx_next(input rx_state_t st, input block_class_t cls);
    rx_state_t nxt;
    nxt = RX_E;
    case (st)
      RX_C: begin
        if (cls == BLK_CTRL) nxt = RX_C;
        else if (cls == BLK_START0 || cls == BLK_START4) nxt = RX_D;
      end
      RX_D: begin
        if (cls == BLK_DATA) nxt = RX_D;
        else if (cls == BLK_TERM) nxt = RX_C;
      end
      default: begin
        if (cls == BLK_CTRL) nxt = RX_C;
        else if (cls == BLK_START0 || cls == BLK_START4) nxt = RX_D;
      end
    endcase
    return nxt;
  endfunction

  // Byte keep for a whole 64-bit block; terminate keeps bytes 1..term_k.
  function automatic logic [7:0] block_keep(input block_class_t cls, input logic [2:0] term_k);
    logic [7:0] keep;
    keep = 8'h00;
    case (cls)
      BLK_DATA:   keep = 8'hff;
      BLK_START0: keep = 8'hfe;
      BLK_START4: keep = 8'he0;
      BLK_TERM: begin
        for (int i = 1; i < 8; i++) begin
          keep[i] = (3'(i) <= term_k);
        end
      end
      default:    keep = 8'h00;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/pcs_dec_block_type.sv
// pcs_dec_block_type
//   Combinational classifier for the first part of a 66b block.
//   Ports:
//     sync_head_i  in  2       sync header of the block
//     data_i       in  DATA_W  first part of the payload (byte 0 = block type)
//     cls_o        out         block class
//     term_k_o     out 3       number of data bytes in a terminate block
//     idle_o       out 1       control block whose codes in this part are all idle
//   With a 32-bit datapath only the codes present in part 0 are checked;
//   the caller extends the idle check over the remaining parts.
module pcs_dec_block_type
  import pcs_pkg::*;
#(
  parameter int IS_40G = 0,
  parameter int DATA_W = 64
) (
  input  logic [1:0]        sync_head_i,
  input  logic [DATA_W-1:0] data_i,
  output block_class_t      cls_o,
  output logic [2:0]        term_k_o,
  output logic              idle_o
);

  logic [7:0] block_type;

  always_comb begin
    cls_o      = BLK_ERR;
    term_k_o   = 3'd0;
    idle_o     = 1'b0;
    block_type = data_i[7:0];
    if (sync_head_i == SYNC_DATA) begin
      cls_o = BLK_DATA;
    end else if (sync_head_i == SYNC_CTRL) begin
      case (block_type)
        BLOCK_TYPE_CTRL: begin
          cls_o  = BLK_CTRL;
          idle_o = (data_i == IDLE_BLOCK[DATA_W-1:0]);
        end
        BLOCK_TYPE_START0: cls_o = BLK_START0;
        // Lane-4 start is not a legal alignment on the 40G variant.
        BLOCK_TYPE_START4: cls_o = (IS_40G != 0) ? BLK_ERR : BLK_START4;
        BLOCK_TYPE_TERM0: begin cls_o = BLK_TERM; term_k_o = 3'd0; end
        BLOCK_TYPE_TERM1: begin cls_o = BLK_TERM; term_k_o = 3'd1; end
        BLOCK_TYPE_TERM2: begin cls_o = BLK_TERM; term_k_o = 3'd2; end
        BLOCK_TYPE_TERM3: begin cls_o = BLK_TERM; term_k_o = 3'd3; end
        BLOCK_TYPE_TERM4: begin cls_o = BLK_TERM; term_k_o = 3'd4; end
        BLOCK_TYPE_TERM5: begin cls_o = BLK_TERM; term_k_o = 3'd5; end
        BLOCK_TYPE_TERM6: begin cls_o = BLK_TERM; term_k_o = 3'd6; end
        BLOCK_TYPE_TERM7: begin cls_o = BLK_TERM; term_k_o = 3'd7; end
        default:          cls_o = BLK_ERR;
      endcase
    end
  end

endmodule

// File: rtl/pcs_dec_lite.sv
// pcs_dec_lite
//   Receive-side 64b/66b PCS decoder (after block lock / descrambler).
//   Classifies each block, tracks packet framing and emits data with byte keep.
//   All outputs are registered: a beat accepted at cycle N appears at N+1.
//   Ports:
//     clk, reset     clock and synchronous active-high reset
//     valid_i        input beat valid (gearbox bubble when 0)
//     head_v_i       beat is part 0 of a block
//     sync_head_i    sync header (meaningful with head_v_i)
//     data_i         descrambled payload part
//     valid_o        output beat valid
//     ctrl_v_o       block is a control block
//     idle_v_o       block is an all-idle control block
//     start_o        [0] start at byte 0, [1] start at byte 4 (absent on 40G)
//     term_o         block is a terminate block
//     err_o          block rejected
//     data_o         payload passed through
//     keep_o         per-byte packet data flags
//     err_cnt_o      saturating count of rejected blocks (only with
//                    PCS_DEC_ERR_CNT_EN defined)
//   A beat without head_v_i while a new block is expected is treated as a
//   one-beat rejected block; head_v_i arriving mid-block abandons the old
//   block and starts a rejected one.
module pcs_dec_lite
  import pcs_pkg::*;
#(
  parameter int IS_40G      = 0,
  parameter int DATA_W      = 64,
  parameter int BLOCK_W     = 64,
  parameter int CNT_N       = BLOCK_W / DATA_W,
  parameter int KEEP_W      = DATA_W / 8,
  parameter int LANE0_CNT_N = (IS_40G != 0) ? 1 : 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic                   head_v_i,
  input  logic [1:0]             sync_head_i,
  input  logic [DATA_W-1:0]      data_i,
  output logic                   valid_o,
  output logic                   ctrl_v_o,
  output logic                   idle_v_o,
  output logic [LANE0_CNT_N-1:0] start_o,
  output logic                   term_o,
  output logic                   err_o,
  output logic [DATA_W-1:0]      data_o,
  output logic [KEEP_W-1:0]      keep_o
`ifdef PCS_DEC_ERR_CNT_EN
  ,
  output logic [15:0]            err_cnt_o
`endif
);

  localparam int CNT_W = (CNT_N > 1) ? $clog2(CNT_N) : 1;

  // Classifier
  block_class_t cls_c;
  logic [2:0]   term_k_c;
  logic         idle_c;

  pcs_dec_block_type #(
    .IS_40G (IS_40G),
    .DATA_W (DATA_W)
  ) u_block_type (
    .sync_head_i (sync_head_i),
    .data_i      (data_i),
    .cls_o       (cls_c),
    .term_k_o    (term_k_c),
    .idle_o      (idle_c)
  );

  // State
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rx_state_t        state_q;
  block_class_t     cls_q;
  logic [7:0]       keep_blk_q;
  logic             idle_q;

  // Output registers
  logic                   valid_q, ctrl_v_q, idle_v_q, term_q, err_q;
  logic [LANE0_CNT_N-1:0] start_q;
  logic [DATA_W-1:0]      data_q;
  logic [KEEP_W-1:0]      keep_q;

  // Per-beat decode
  logic             orphan, align_err, first_beat, last_beat;
  logic [CNT_W-1:0] part_idx;
  block_class_t     cur_cls;
  logic [7:0]       cur_keep;
  logic             cur_idle, idle_part, blk_err, is_ctrl;
  logic [KEEP_W-1:0]      keep_part;
  logic [LANE0_CNT_N-1:0] start_d;
  rx_state_t        nxt_state;

  always_comb begin
    // counter==0 means a block header is expected on this beat
    orphan     = !head_v_i && (cnt_q == '0);
    align_err  = orphan || (head_v_i && (cnt_q != '0));
    first_beat = head_v_i || orphan;
    part_idx   = head_v_i ? '0 : cnt_q;
    last_beat  = orphan || (part_idx == CNT_W'(CNT_N - 1));

    cur_cls = cls_q;
    if (first_beat) cur_cls = align_err ? BLK_ERR : cls_c;

    cur_keep = first_beat ? block_keep(cur_cls, term_k_c) : keep_blk_q;
    // idle flag accumulates over the parts of a block
    cur_idle = first_beat ? (idle_c && !align_err) : (idle_q && idle_part);

    // Error status is known from the first part because the transition
    // depends only on the current state and the class of the block.
    nxt_state = rx_next(state_q, cur_cls);
    blk_err   = (nxt_state == RX_E);
    is_ctrl   = cur_cls inside {BLK_CTRL, BLK_START0, BLK_START4, BLK_TERM};

    if (head_v_i) begin
      cnt_d = (CNT_N > 1) ? CNT_W'(1) : '0;
    end else if (orphan) begin
      cnt_d = '0;
    end else begin
      cnt_d = (cnt_q == CNT_W'(CNT_N - 1)) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  generate
    if (CNT_N > 1) begin : g_multi_part
      always_comb begin
        keep_part = cur_keep[part_idx*KEEP_W +: KEEP_W];
        idle_part = (data_i == IDLE_BLOCK[part_idx*DATA_W +: DATA_W]);
      end
    end else begin : g_single_part
      always_comb begin
        keep_part = cur_keep[KEEP_W-1:0];
        idle_part = (data_i == IDLE_BLOCK[DATA_W-1:0]);
      end
    end

    if (LANE0_CNT_N == 1) begin : g_start_lane0
      always_comb start_d = (cur_cls == BLK_START0);
    end else begin : g_start_dual
      always_comb start_d = {cur_cls == BLK_START4, cur_cls == BLK_START0};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      ctrl_v_q   <= 1'b0;
      idle_v_q   <= 1'b0;
      start_q    <= '0;
      term_q     <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      keep_q     <= '0;
      cnt_q      <= '0;
      state_q    <= RX_C;
      cls_q      <= BLK_CTRL;
      keep_blk_q <= '0;
      idle_q     <= 1'b0;
    end else begin
      valid_q  <= valid_i;
      ctrl_v_q <= valid_i && is_ctrl;
      idle_v_q <= valid_i && cur_idle;
      start_q  <= (valid_i && !blk_err) ? start_d : '0;
      term_q   <= valid_i && !blk_err && (cur_cls == BLK_TERM);
      err_q    <= valid_i && blk_err;
      keep_q   <= (valid_i && !blk_err) ? keep_part : '0;
      data_q   <= valid_i ? data_i : '0;
      if (valid_i) begin
        cnt_q      <= cnt_d;
        cls_q      <= cur_cls;
        keep_blk_q <= cur_keep;
        idle_q     <= cur_idle;
        if (last_beat) state_q <= nxt_state;
      end
    end
  end

  assign valid_o  = valid_q;
  assign ctrl_v_o = ctrl_v_q;
  assign idle_v_o = idle_v_q;
  assign start_o  = start_q;
  assign term_o   = term_q;
  assign err_o    = err_q;
  assign data_o   = data_q;
  assign keep_o   = keep_q;

`ifdef PCS_DEC_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // One count per rejected block, taken on its first beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= 16'h0000;
    end else if (valid_i && first_beat && blk_err && (err_cnt_q != 16'hffff)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  // Error counter not built.
`endif

endmodule

// File: tb/tb_pcs_dec_lite.sv
module tb_pcs_dec_lite;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 64-bit instance
  logic        rst64, v64, h64;
  logic [1:0]  sh64;
  logic [63:0] d64;
  logic        vo64, cv64, iv64, to64, eo64;
  logic [1:0]  st64;
  logic [63:0] do64;
  logic [7:0]  ko64;

  // 32-bit instance
  logic        rst32, v32, h32;
  logic [1:0]  sh32;
  logic [31:0] d32;
  logic        vo32, cv32, iv32, to32, eo32;
  logic [1:0]  st32;
  logic [31:0] do32;
  logic [3:0]  ko32;

`ifdef PCS_DEC_ERR_CNT_EN
  logic [15:0] ec64, ec32;
`endif

  pcs_dec_lite #(.IS_40G(0), .DATA_W(64)) dut (
    .clk(clk), .reset(rst64), .valid_i(v64), .head_v_i(h64), .sync_head_i(sh64),
    .data_i(d64), .valid_o(vo64), .ctrl_v_o(cv64), .idle_v_o(iv64), .start_o(st64),
    .term_o(to64), .err_o(eo64), .data_o(do64), .keep_o(ko64)
`ifdef PCS_DEC_ERR_CNT_EN
    , .err_cnt_o(ec64)
`endif
  );

  pcs_dec_lite #(.IS_40G(0), .DATA_W(32)) dut32 (
    .clk(clk), .reset(rst32), .valid_i(v32), .head_v_i(h32), .sync_head_i(sh32),
    .data_i(d32), .valid_o(vo32), .ctrl_v_o(cv32), .idle_v_o(iv32), .start_o(st32),
    .term_o(to32), .err_o(eo32), .data_o(do32), .keep_o(ko32)
`ifdef PCS_DEC_ERR_CNT_EN
    , .err_cnt_o(ec32)
`endif
  );

  typedef struct packed {
    logic        ctrl;
    logic        idle;
    logic [1:0]  start;
    logic        term;
    logic        err;
    logic [7:0]  keep;
    logic [63:0] data;
  } exp_t;

  exp_t q64[$];
  exp_t q32[$];
  exp_t e64, e32;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end else begin
      $display("  ok %-8s %h", tag, obs);
    end
  endtask

  function automatic exp_t mk(input logic c, input logic i, input logic [1:0] s, input logic t,
                              input logic e, input logic [7:0] k, input logic [63:0] d);
    exp_t r;
    r.ctrl = c; r.idle = i; r.start = s; r.term = t; r.err = e; r.keep = k; r.data = d;
    return r;
  endfunction

  // Scoreboard checkers: one expected entry per output beat.
  always @(negedge clk) begin
    if (vo64) begin
      if (q64.size() == 0) begin
        check_val("unexp64", {95'b0, vo64}, 96'b0);
      end else begin
        e64 = q64.pop_front();
        check_val("beat64", 96'(mk(cv64, iv64, st64, to64, eo64, ko64, do64)), 96'(e64));
      end
    end
    if (vo32) begin
      if (q32.size() == 0) begin
        check_val("unexp32", {95'b0, vo32}, 96'b0);
      end else begin
        e32 = q32.pop_front();
        check_val("beat32", 96'(mk(cv32, iv32, st32, to32, eo32, {4'b0, ko32}, {32'b0, do32})), 96'(e32));
      end
    end
  end

  task automatic drive64(input logic hv, input logic [1:0] hdr, input logic [63:0] d, input exp_t e);
    @(negedge clk);
    v64 = 1'b1; h64 = hv; sh64 = hdr; d64 = d;
    q64.push_back(e);
  endtask

  task automatic drive32(input logic hv, input logic [1:0] hdr, input logic [31:0] d, input exp_t e);
    @(negedge clk);
    v32 = 1'b1; h32 = hv; sh32 = hdr; d32 = d;
    q32.push_back(e);
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      @(negedge clk);
      v64 = 1'b0; h64 = 1'b0; v32 = 1'b0; h32 = 1'b0;
    end
  endtask

  logic [63:0] idle_blk, bad_idle, s0, s4, d1, d2, tcc, t87, tff, t99, unk;

  initial begin
    idle_blk = {{7{7'h07}}, 8'h1e};
    bad_idle = idle_blk ^ 64'h0000_0001_0000_0000;
    s0  = {56'h11223344556677, 8'h78};
    s4  = {56'h11223300000000, 8'h33};
    d1  = 64'h0123456789abcdef;
    d2  = 64'hfedcba9876543210;
    tcc = {56'h000000a4a3a2a1, 8'hcc};
    t87 = {56'h00000000000000, 8'h87};
    tff = {56'h77665544332211, 8'hff};
    t99 = {56'h000000000000c1, 8'h99};
    unk = {56'h00000000000000, 8'h4b};

    rst64 = 1'b1; rst32 = 1'b1;
    v64 = 1'b0; h64 = 1'b0; sh64 = 2'b00; d64 = '0;
    v32 = 1'b0; h32 = 1'b0; sh32 = 2'b00; d32 = '0;
    repeat (3) @(negedge clk);
    check_val("rst64", 96'({vo64, mk(cv64, iv64, st64, to64, eo64, ko64, do64)}), 96'd0);
    check_val("rst32", 96'({vo32, mk(cv32, iv32, st32, to32, eo32, {4'b0, ko32}, {32'b0, do32})}), 96'd0);
    rst64 = 1'b0; rst32 = 1'b0;

    // ---- 64-bit datapath ----
    drive64(1, 2'b10, idle_blk, mk(1, 1, 2'b00, 0, 0, 8'h00, idle_blk));
    drive64(1, 2'b10, s0,       mk(1, 0, 2'b01, 0, 0, 8'hfe, s0));
    drive64(1, 2'b01, d1,       mk(0, 0, 2'b00, 0, 0, 8'hff, d1));
    drive64(1, 2'b01, d2,       mk(0, 0, 2'b00, 0, 0, 8'hff, d2));
    drive64(1, 2'b10, tcc,      mk(1, 0, 2'b00, 1, 0, 8'h1e, tcc));
    drive64(1, 2'b01, d1,       mk(0, 0, 2'b00, 0, 1, 8'h00, d1));       // data while idle
    drive64(1, 2'b10, idle_blk, mk(1, 1, 2'b00, 0, 0, 8'h00, idle_blk)); // recover
    drive64(1, 2'b10, s0,       mk(1, 0, 2'b01, 0, 0, 8'hfe, s0));
    drive64(1, 2'b01, d1,       mk(0, 0, 2'b00, 0, 0, 8'hff, d1));
    drive64(1, 2'b11, d2,       mk(0, 0, 2'b00, 0, 1, 8'h00, d2));       // bad header
    drive64(1, 2'b01, d1,       mk(0, 0, 2'b00, 0, 1, 8'h00, d1));
    drive64(1, 2'b01, d2,       mk(0, 0, 2'b00, 0, 1, 8'h00, d2));
    bubble(2);
    drive64(1, 2'b01, d1,       mk(0, 0, 2'b00, 0, 1, 8'h00, d1));       // error state held
    drive64(1, 2'b10, s0,       mk(1, 0, 2'b01, 0, 0, 8'hfe, s0));
    drive64(1, 2'b10, t87,      mk(1, 0, 2'b00, 1, 0, 8'h00, t87));
    drive64(1, 2'b10, s4,       mk(1, 0, 2'b10, 0, 0, 8'he0, s4));
    drive64(1, 2'b01, d1,       mk(0, 0, 2'b00, 0, 0, 8'hff, d1));
    drive64(1, 2'b10, tff,      mk(1, 0, 2'b00, 1, 0, 8'hfe, tff));
    drive64(1, 2'b10, bad_idle, mk(1, 0, 2'b00, 0, 0, 8'h00, bad_idle));
    drive64(1, 2'b10, unk,      mk(0, 0, 2'b00, 0, 1, 8'h00, unk));
    drive64(1, 2'b10, idle_blk, mk(1, 1, 2'b00, 0, 0, 8'h00, idle_blk));
    drive64(0, 2'b10, idle_blk, mk(0, 0, 2'b00, 0, 1, 8'h00, idle_blk)); // missing head_v_i
    drive64(1, 2'b10, idle_blk, mk(1, 1, 2'b00, 0, 0, 8'h00, idle_blk));
    drive64(1, 2'b10, t99,      mk(1, 0, 2'b00, 0, 1, 8'h00, t99));      // term while idle
    drive64(1, 2'b10, idle_blk, mk(1, 1, 2'b00, 0, 0, 8'h00, idle_blk));
    drive64(1, 2'b00, d1,       mk(0, 0, 2'b00, 0, 1, 8'h00, d1));       // header 00
    drive64(1, 2'b10, idle_blk, mk(1, 1, 2'b00, 0, 0, 8'h00, idle_blk));
    bubble(3);

`ifdef PCS_DEC_ERR_CNT_EN
    @(negedge clk); rst64 = 1'b1;
    @(negedge clk); rst64 = 1'b0;
    check_val("errcnt0", 96'(ec64), 96'd0);
    drive64(1, 2'b00, d1, mk(0, 0, 2'b00, 0, 1, 8'h00, d1));
    drive64(1, 2'b11, d2, mk(0, 0, 2'b00, 0, 1, 8'h00, d2));
    drive64(1, 2'b00, d1, mk(0, 0, 2'b00, 0, 1, 8'h00, d1));
    bubble(1);
    check_val("errcnt3", 96'(ec64), 96'd3);
    bubble(2);
`endif

    // ---- 32-bit datapath: two parts per block ----
    drive32(1, 2'b10, idle_blk[31:0],  mk(1, 1, 2'b00, 0, 0, 8'h0, {32'b0, idle_blk[31:0]}));
    drive32(0, 2'b00, idle_blk[63:32], mk(1, 1, 2'b00, 0, 0, 8'h0, {32'b0, idle_blk[63:32]}));
    drive32(1, 2'b10, s0[31:0],        mk(1, 0, 2'b01, 0, 0, 8'he, {32'b0, s0[31:0]}));
    drive32(0, 2'b00, s0[63:32],       mk(1, 0, 2'b01, 0, 0, 8'hf, {32'b0, s0[63:32]}));
    drive32(1, 2'b01, d1[31:0],        mk(0, 0, 2'b00, 0, 0, 8'hf, {32'b0, d1[31:0]}));
    drive32(0, 2'b00, d1[63:32],       mk(0, 0, 2'b00, 0, 0, 8'hf, {32'b0, d1[63:32]}));
    drive32(1, 2'b10, tcc[31:0],       mk(1, 0, 2'b00, 1, 0, 8'he, {32'b0, tcc[31:0]}));
    drive32(0, 2'b00, tcc[63:32],      mk(1, 0, 2'b00, 1, 0, 8'h1, {32'b0, tcc[63:32]}));
    // head_v_i where part 1 was expected
    drive32(1, 2'b10, s0[31:0],        mk(1, 0, 2'b01, 0, 0, 8'he, {32'b0, s0[31:0]}));
    drive32(1, 2'b01, d1[31:0],        mk(0, 0, 2'b00, 0, 1, 8'h0, {32'b0, d1[31:0]}));
    drive32(0, 2'b00, d1[63:32],       mk(0, 0, 2'b00, 0, 1, 8'h0, {32'b0, d1[63:32]}));
    drive32(1, 2'b10, idle_blk[31:0],  mk(1, 1, 2'b00, 0, 0, 8'h0, {32'b0, idle_blk[31:0]}));
    drive32(0, 2'b00, idle_blk[63:32], mk(1, 1, 2'b00, 0, 0, 8'h0, {32'b0, idle_blk[63:32]}));
    // reset mid-packet, mid-block
    drive32(1, 2'b10, s0[31:0],        mk(1, 0, 2'b01, 0, 0, 8'he, {32'b0, s0[31:0]}));
    drive32(0, 2'b00, s0[63:32],       mk(1, 0, 2'b01, 0, 0, 8'hf, {32'b0, s0[63:32]}));
    drive32(1, 2'b01, d1[31:0],        mk(0, 0, 2'b00, 0, 0, 8'hf, {32'b0, d1[31:0]}));
    @(negedge clk); v32 = 1'b0; h32 = 1'b0; rst32 = 1'b1;
    @(negedge clk); rst32 = 1'b0;
    check_val("rst32b", 96'({vo32, mk(cv32, iv32, st32, to32, eo32, {4'b0, ko32}, {32'b0, do32})}), 96'd0);
    drive32(1, 2'b10, s0[31:0],        mk(1, 0, 2'b01, 0, 0, 8'he, {32'b0, s0[31:0]}));
    drive32(0, 2'b00, s0[63:32],       mk(1, 0, 2'b01, 0, 0, 8'hf, {32'b0, s0[63:32]}));
    bubble(3);

    check_val("drain64", 96'(q64.size()), 96'd0);
    check_val("drain32", 96'(q32.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
